// File: rtl/lcd_text_timing.sv
// DE-mode LCD raster timing and text-cell address generator, free-running, no backpressure.
// Latency: (h,v) -> Text_Addr 1 cycle; -> LCD_DE/Glyph_X/Glyph_Y 1+RAM_LATENCY cycles.
module lcd_text_timing #(
    parameter int H_ACTIVE    = 480,
    parameter int H_BACK      = 43,
    parameter int H_FRONT     = 8,
    parameter int V_ACTIVE    = 272,
    parameter int V_BACK      = 12,
    parameter int V_FRONT     = 8,
    parameter int CHAR_W      = 8,
    parameter int CHAR_H      = 16,
    parameter int RAM_LATENCY = 2,
    localparam int H_TOTAL = H_BACK + H_ACTIVE + H_FRONT,
    localparam int V_TOTAL = V_BACK + V_ACTIVE + V_FRONT,
    localparam int COLS    = H_ACTIVE / CHAR_W,
    localparam int ROWS    = V_ACTIVE / CHAR_H,
    localparam int ADDR_W  = $clog2(COLS * ROWS),
    localparam int ROW_W   = $clog2(ROWS),
    localparam int GX_W    = $clog2(CHAR_W),
    localparam int GY_W    = $clog2(CHAR_H)
) (
    input  logic              PixelClk,
    input  logic              Rst,
    input  logic [ROW_W-1:0]  Scroll_Row,
    output logic [ADDR_W-1:0] Text_Addr,
    output logic              LCD_DE,
    output logic [GX_W-1:0]   Glyph_X,
    output logic [GY_W-1:0]   Glyph_Y,
    output logic              Frame_Start,
    output logic              Vblank,
    output logic [7:0]        Frame_Cnt
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [HW-1:0]    h;
    logic [VW-1:0]    v;
    logic [ROW_W-1:0] scroll;
    logic             at_origin;
    logic             h_last;
    logic             v_last;
    logic             active;
    logic             v_blank_now;
    logic [HW-1:0]    px;
    logic [VW-1:0]    py;
    logic [ROW_W:0]   drow_sum;
    logic [ROW_W:0]   drow;
    logic [ADDR_W-1:0] addr_next;

    logic [RAM_LATENCY:0] de_pipe;
    logic [GX_W-1:0]      gx_pipe [RAM_LATENCY+1];
    logic [GY_W-1:0]      gy_pipe [RAM_LATENCY+1];

    always_comb begin
        at_origin   = (h == '0) && (v == '0);
        h_last      = (h == HW'(H_TOTAL - 1));
        v_last      = (v == VW'(V_TOTAL - 1));
        v_blank_now = (v < VW'(V_BACK)) || (v >= VW'(V_BACK + V_ACTIVE));
        active      = (h >= HW'(H_BACK)) && (h < HW'(H_BACK + H_ACTIVE)) && !v_blank_now;
        px          = h - HW'(H_BACK);
        py          = v - VW'(V_BACK);
        // prow < ROWS and scroll < ROWS, so one conditional subtract folds the wrap
        drow_sum    = {1'b0, ROW_W'(py[VW-1:GY_W])} + {1'b0, scroll};
        drow        = (drow_sum >= (ROW_W+1)'(ROWS)) ? drow_sum - (ROW_W+1)'(ROWS) : drow_sum;
        addr_next   = ADDR_W'(drow) * ADDR_W'(COLS) + ADDR_W'(px[HW-1:GX_W]);
    end

    always_ff @(posedge PixelClk) begin
        if (Rst) begin
            h           <= '0;
            v           <= '0;
            scroll      <= '0;
            Text_Addr   <= '0;
            Frame_Start <= 1'b0;
            Frame_Cnt   <= '0;
            Vblank      <= 1'b1;
        end else begin
            h <= h_last ? '0 : h + 1'b1;
            if (h_last) begin
                v <= v_last ? '0 : v + 1'b1;
            end
            // Scroll only changes at the frame origin so a frame is never torn
            if (at_origin && (Scroll_Row < ROW_W'(ROWS))) begin
                scroll <= Scroll_Row;
            end
            if (active) begin
                Text_Addr <= addr_next;
            end
            Frame_Start <= at_origin;
            if (at_origin) begin
                Frame_Cnt <= Frame_Cnt + 8'd1;
            end
            Vblank <= v_blank_now;
        end
    end

    always_ff @(posedge PixelClk) begin
        if (Rst) begin
            de_pipe <= '0;
            for (int i = 0; i <= RAM_LATENCY; i++) begin
                gx_pipe[i] <= '0;
                gy_pipe[i] <= '0;
            end
        end else begin
            de_pipe    <= {de_pipe[RAM_LATENCY-1:0], active};
            gx_pipe[0] <= active ? px[GX_W-1:0] : '0;
            gy_pipe[0] <= active ? py[GY_W-1:0] : '0;
            for (int i = 1; i <= RAM_LATENCY; i++) begin
                gx_pipe[i] <= gx_pipe[i-1];
                gy_pipe[i] <= gy_pipe[i-1];
            end
        end
    end

    assign LCD_DE  = de_pipe[RAM_LATENCY];
    assign Glyph_X = gx_pipe[RAM_LATENCY];
    assign Glyph_Y = gy_pipe[RAM_LATENCY];
endmodule

// File: tb/tb_lcd_text_timing.sv
// Bench for lcd_text_timing on a reduced raster so a full Frame_Cnt wrap fits the cycle budget.
module tb_lcd_text_timing;
    localparam int HA = 16, HB = 3, HF = 2;
    localparam int VA = 12, VB = 2, VF = 1;
    localparam int CW = 4, CH = 4, RL = 2;
    localparam int HT = HB + HA + HF;
    localparam int VT = VB + VA + VF;
    localparam int FRAME = HT * VT;
    localparam int COLS = HA / CW, ROWS = VA / CH;
    localparam int AW = $clog2(COLS * ROWS), RW = $clog2(ROWS);
    localparam int GXW = $clog2(CW), GYW = $clog2(CH);
    // Two mid-frame resets, each landing on an active pixel (second on the last column)
    localparam int R1 = FRAME + (VB + 1) * HT + HB + 3;
    localparam int R2 = 2 * FRAME + (VB + 7) * HT + HB + HA - 1;
    localparam int FINAL_N = 258 * FRAME + 20;

    logic           PixelClk = 1'b0;
    logic           Rst;
    logic [RW-1:0]  Scroll_Row;
    logic [AW-1:0]  Text_Addr;
    logic           LCD_DE;
    logic [GXW-1:0] Glyph_X;
    logic [GYW-1:0] Glyph_Y;
    logic           Frame_Start;
    logic           Vblank;
    logic [7:0]     Frame_Cnt;

    always #5 PixelClk = ~PixelClk;

    lcd_text_timing #(
        .H_ACTIVE(HA), .H_BACK(HB), .H_FRONT(HF),
        .V_ACTIVE(VA), .V_BACK(VB), .V_FRONT(VF),
        .CHAR_W(CW), .CHAR_H(CH), .RAM_LATENCY(RL)
    ) dut (
        .PixelClk(PixelClk), .Rst(Rst), .Scroll_Row(Scroll_Row),
        .Text_Addr(Text_Addr), .LCD_DE(LCD_DE), .Glyph_X(Glyph_X), .Glyph_Y(Glyph_Y),
        .Frame_Start(Frame_Start), .Vblank(Vblank), .Frame_Cnt(Frame_Cnt)
    );

    typedef struct packed {
        logic [AW-1:0]  addr;
        logic           de;
        logic [GXW-1:0] gx;
        logic [GYW-1:0] gy;
        logic           fs;
        logic           vb;
        logic [7:0]     fc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails = 0;
    int   edge_idx = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_idx, act, expv);
        end
    endtask

    // Pixel attributes of raster position n counted from reset release
    function automatic void pix(input int n, output bit act, output int gx, output int gy,
                                output int prow, output int col, output bit vbl);
        int hh, vv;
        hh   = n % HT;
        vv   = (n / HT) % VT;
        vbl  = (vv < VB) || (vv >= VB + VA);
        act  = !vbl && (hh >= HB) && (hh < HB + HA);
        gx   = act ? (hh - HB) % CW : 0;
        gy   = act ? (vv - VB) % CH : 0;
        prow = (vv - VB) / CH;
        col  = (hh - HB) / CW;
    endfunction

    // Monitor: one expectation per clock edge, compared away from the edge
    always @(negedge PixelClk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            edge_idx++;
            check("text_addr",   int'(Text_Addr),   int'(mon_e.addr));
            check("lcd_de",      int'(LCD_DE),      int'(mon_e.de));
            check("glyph_x",     int'(Glyph_X),     int'(mon_e.gx));
            check("glyph_y",     int'(Glyph_Y),     int'(mon_e.gy));
            check("frame_start", int'(Frame_Start), int'(mon_e.fs));
            check("vblank",      int'(Vblank),      int'(mon_e.vb));
            check("frame_cnt",   int'(Frame_Cnt),   int'(mon_e.fc));
        end
    end

    // Stimulus and reference model: each cycle drives inputs and predicts the next edge
    initial begin
        int   n, last_addr, cur_scroll, rst_left, phase;
        int   gx, gy, prow, col, gx2, gy2, prow2, col2;
        bit   act, vbl, act2, vbl2, running;
        exp_t em;
        n = 0; last_addr = 0; cur_scroll = 0; rst_left = 3; phase = 0; running = 1'b1;
        Rst = 1'b1;
        Scroll_Row = '0;
        #1;
        while (running) begin
            if ($urandom_range(0, 49) == 0) Scroll_Row = RW'($urandom_range(0, 3));
            if (rst_left == 0) begin
                if (phase == 0 && n == R1) begin rst_left = 2; phase = 1; end
                else if (phase == 1 && n == R2) begin rst_left = 3; phase = 2; end
            end
            Rst = (rst_left > 0);
            if (Rst) begin
                rst_left--;
                n = 0; last_addr = 0; cur_scroll = 0;
                em = '{addr: '0, de: 1'b0, gx: '0, gy: '0, fs: 1'b0, vb: 1'b1, fc: '0};
            end else begin
                pix(n, act, gx, gy, prow, col, vbl);
                if (n % FRAME == 0 && int'(Scroll_Row) < ROWS) cur_scroll = int'(Scroll_Row);
                if (act) last_addr = ((prow + cur_scroll) % ROWS) * COLS + col;
                if (n >= 2) pix(n - 2, act2, gx2, gy2, prow2, col2, vbl2);
                else begin act2 = 1'b0; gx2 = 0; gy2 = 0; end
                em.addr = AW'(last_addr);
                em.de   = act2;
                em.gx   = GXW'(gx2);
                em.gy   = GYW'(gy2);
                em.fs   = (n % FRAME == 0);
                em.vb   = vbl;
                em.fc   = 8'((n / FRAME + 1) % 256);
                n++;
                if (phase == 2 && n > FINAL_N) running = 1'b0;
            end
            q.push_back(em);
            @(posedge PixelClk);
            #1;
        end
        repeat (3) @(negedge PixelClk);
        check("queue_drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
